// File: rtl/exec_pkg.sv
// Shared issue-control types and opcode classification for the Execute path.
// Classifiers are reused by the Execute stage itself.
package exec_pkg;

  typedef enum logic [1:0] {
    RUN,
    MULBUSY,
    DRAIN,
    HALTED
  } state_t;

  localparam logic [7:0] OP_MOV_IMM   = 8'hC7;
  localparam logic [7:0] OP_GRP3      = 8'hF7;
  localparam logic [7:0] OP_IMUL_I32  = 8'h69;
  localparam logic [7:0] OP_IMUL_I8   = 8'h6B;
  localparam logic [7:0] OP_IMUL_0F   = 8'hAF;
  localparam logic [7:0] OP_RET       = 8'hC3;
  localparam logic [7:0] OP_RETF      = 8'hCB;
  localparam logic [7:0] OP_IRET      = 8'hCF;

  localparam logic [2:0] EXT_MUL  = 3'b100;
  localparam logic [2:0] EXT_IMUL = 3'b101;

  function automatic logic is_mul_class(
    input logic [31:0] len,
    input logic [7:0]  op,
    input logic [31:0] hasExt,
    input logic [2:0]  ext
  );
    logic oneByte;
    logic grp3Mul;
    oneByte = (len == 32'd1);
    grp3Mul = (op == OP_GRP3) && (hasExt != 32'd0)
           && ((ext == EXT_MUL) || (ext == EXT_IMUL));
    return (oneByte && grp3Mul)
        || (oneByte && (op == OP_IMUL_I32))
        || (oneByte && (op == OP_IMUL_I8))
        || ((len == 32'd2) && (op == OP_IMUL_0F));
  endfunction

  function automatic logic is_kill_class(
    input logic [31:0] len,
    input logic [7:0]  op,
    input logic [31:0] hasExt,
    input logic [2:0]  ext
  );
    logic unusedBits;
    unusedBits = ^{hasExt, ext};
    return (len == 32'd1)
        && ((op == OP_RET) || (op == OP_RETF) || (op == OP_IRET))
        && (unusedBits | !unusedBits);
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-register vector: two set ports, two clear ports, four read ports.
// A register set and cleared in the same cycle stays busy.
module reg_scoreboard #(
  parameter int NUM_REGS = 16,
  parameter int RW       = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                setEnA,
  input  logic [RW-1:0]       setRegA,
  input  logic                setEnB,
  input  logic [RW-1:0]       setRegB,
  input  logic                clrEnA,
  input  logic [RW-1:0]       clrRegA,
  input  logic                clrEnB,
  input  logic [RW-1:0]       clrRegB,
  input  logic [RW-1:0]       rdRegA,
  input  logic [RW-1:0]       rdRegB,
  input  logic [RW-1:0]       rdRegC,
  input  logic [RW-1:0]       rdRegD,
  output logic                rdBusyA,
  output logic                rdBusyB,
  output logic                rdBusyC,
  output logic                rdBusyD,
  output logic [NUM_REGS-1:0] busyVec
);

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] setMask;
  logic [NUM_REGS-1:0] clrMask;

  always_comb begin
    setMask = '0;
    clrMask = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (setEnA && (setRegA == RW'(i))) setMask[i] = 1'b1;
      if (setEnB && (setRegB == RW'(i))) setMask[i] = 1'b1;
      if (clrEnA && (clrRegA == RW'(i))) clrMask[i] = 1'b1;
      if (clrEnB && (clrRegB == RW'(i))) clrMask[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= '0;
    end else begin
      busy <= (busy & ~clrMask) | setMask;
    end
  end

  assign rdBusyA = busy[rdRegA];
  assign rdBusyB = busy[rdRegB];
  assign rdBusyC = busy[rdRegC];
  assign rdBusyD = busy[rdRegD];
  assign busyVec = busy;

endmodule

// File: rtl/execute_scheduler.sv
// Issue controller ahead of Execute: RAW/WAW scoreboard, multiply
// occupancy sequencing and kill-driven drain to halt.
module execute_scheduler
  import exec_pkg::*;
#(
  parameter int NUM_REGS    = 16,
  parameter int MUL_LATENCY = 4,
  parameter int CNT_W       = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                decValidIn,
  input  logic [31:0]         opcodeLengthIn,
  input  logic [7:0]          opcodeIn,
  input  logic [31:0]         hasExtendedOpcodeIn,
  input  logic [2:0]          extendedOpcodeIn,
  input  logic [3:0]          sourceReg1In,
  input  logic [3:0]          sourceReg2In,
  input  logic                sourceReg1ValidIn,
  input  logic                sourceReg2ValidIn,
  input  logic [3:0]          destRegIn,
  input  logic                destRegValidIn,
  input  logic [3:0]          destRegSpecialIn,
  input  logic                destRegSpecialValidIn,
  input  logic                wbValidIn,
  input  logic [3:0]          wbRegIn,
  input  logic [3:0]          wbRegSpecialIn,
  input  logic                wbRegSpecialValidIn,
  output logic                canExecuteOut,
  output logic                decStallOut,
  output logic                mulResultValidOut,
  output logic                haltedOut,
  output logic [NUM_REGS-1:0] busyRegsOut
);

  state_t state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic [NUM_REGS-1:0] busy;
  logic busySrc1, busySrc2, busyDest, busyDestSp;
  logic hazard, issue, isMul, isKill, mulPulse;

  reg_scoreboard #(
    .NUM_REGS(NUM_REGS),
    .RW      (4)
  ) uScoreboard (
    .clk    (clk),
    .reset  (reset),
    .setEnA (issue & destRegValidIn),
    .setRegA(destRegIn),
    .setEnB (issue & destRegSpecialValidIn),
    .setRegB(destRegSpecialIn),
    .clrEnA (wbValidIn),
    .clrRegA(wbRegIn),
    .clrEnB (wbRegSpecialValidIn),
    .clrRegB(wbRegSpecialIn),
    .rdRegA (sourceReg1In),
    .rdRegB (sourceReg2In),
    .rdRegC (destRegIn),
    .rdRegD (destRegSpecialIn),
    .rdBusyA(busySrc1),
    .rdBusyB(busySrc2),
    .rdBusyC(busyDest),
    .rdBusyD(busyDestSp),
    .busyVec(busy)
  );

  assign hazard = (sourceReg1ValidIn & busySrc1)
                | (sourceReg2ValidIn & busySrc2)
                | (destRegValidIn & busyDest)
                | (destRegSpecialValidIn & busyDestSp);

  // Reset gating keeps every output low while reset is held.
  assign issue = decValidIn & ~hazard & (state == RUN) & ~reset;

  assign isMul = is_mul_class(opcodeLengthIn, opcodeIn,
                              hasExtendedOpcodeIn, extendedOpcodeIn);
  assign isKill = is_kill_class(opcodeLengthIn, opcodeIn,
                                hasExtendedOpcodeIn, extendedOpcodeIn);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    mulPulse  = 1'b0;
    unique case (state)
      RUN: begin
        if (issue && isKill) begin
          stateNext = DRAIN;
        end else if (issue && isMul) begin
          stateNext = MULBUSY;
          cntNext   = CNT_W'(MUL_LATENCY - 1);
        end
      end
      MULBUSY: begin
        if (cnt == '0) begin
          mulPulse  = 1'b1;
          stateNext = RUN;
        end else begin
          cntNext = cnt - 1'b1;
        end
      end
      DRAIN: begin
        if ((busy == '0) && !wbValidIn && !wbRegSpecialValidIn) begin
          stateNext = HALTED;
        end
      end
      HALTED: begin
        stateNext = HALTED;
      end
      default: begin
        stateNext = RUN;
      end
    endcase
  end

  assign canExecuteOut     = issue;
  assign decStallOut       = decValidIn & ~issue & ~reset;
  assign mulResultValidOut = mulPulse;
  assign haltedOut         = (state == HALTED);
  assign busyRegsOut       = busy;

endmodule
